// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier controller: state encoding, control word and its decode.
// Outputs are decoded only from the registered state, so every controller output is Moore.
package mult_pkg;

    localparam int N_BITS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic en_a;
        logic ld_shift_a;
        logic en_b;
        logic ld_shift_b;
        logic en_p;
        logic ld_add_p;
        logic busy;
        logic done;
    } ctrl_t;

    // LOAD leaves every select low: load a, load b and clear p in one cycle.
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            LOAD: begin
                c.en_a = 1'b1;
                c.en_b = 1'b1;
                c.en_p = 1'b1;
                c.busy = 1'b1;
            end
            TEST: begin
                c.busy = 1'b1;
            end
            ADD: begin
                c.en_p     = 1'b1;
                c.ld_add_p = 1'b1;
                c.busy     = 1'b1;
            end
            SHIFT: begin
                c.en_a       = 1'b1;
                c.ld_shift_a = 1'b1;
                c.en_b       = 1'b1;
                c.ld_shift_b = 1'b1;
                c.busy       = 1'b1;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Saturating shift-iteration counter: clear wins over increment, tc flags N_BITS completed shifts.
// Single-cycle update, no backpressure; the count holds whenever neither clear nor inc is asserted.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CW     = $clog2(N_BITS + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(N_BITS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturation keeps the count at N_BITS even if inc is asserted past terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc  = (cnt_q == TC_VAL);
    assign cnt = cnt_q;

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier sequencer; defining MULT_CTRL_EARLY_EXIT_EN lets TEST finish as soon as the multiplier is zero.
// done follows the start edge by 2 + 2*N_BITS + popcount(b) edges; start is a level honoured only in IDLE, done holds while start stays high.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         start,
    input  logic                         zero,
    input  logic                         lsb_b,
    output logic                         en_a,
    output logic                         ld_shift_a,
    output logic                         en_b,
    output logic                         ld_shift_b,
    output logic                         en_p,
    output logic                         ld_add_p,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_BITS+1)-1:0]  iter_cnt
);

    localparam int CW = $clog2(N_BITS + 1);

    state_t        state_q;
    state_t        state_d;
    ctrl_t         ctrl;
    logic          cnt_clear;
    logic          cnt_inc;
    logic          cnt_tc;
    logic          exit_early;
    logic [CW-1:0] cnt_val;

`ifdef MULT_CTRL_EARLY_EXIT_EN
    assign exit_early = zero;
`else
    logic unused_zero;
    assign exit_early  = 1'b0;
    assign unused_zero = zero;
`endif

    // Counter controls are decoded from the registered state so the count moves on the edge leaving LOAD/SHIFT.
    assign cnt_clear = (state_q == LOAD);
    assign cnt_inc   = (state_q == SHIFT);

    mult_iter_counter #(
        .N_BITS (N_BITS),
        .CW     (CW)
    ) u_iter_counter (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .cnt    (cnt_val),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = TEST;
            end
            TEST: begin
                if (cnt_tc || exit_early) begin
                    state_d = DONE;
                end else if (lsb_b) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                state_d = TEST;
            end
            DONE: begin
                // A held start must not re-launch; the request has to drop back through IDLE first.
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl       = decode_ctrl(state_q);
    assign en_a       = ctrl.en_a;
    assign ld_shift_a = ctrl.ld_shift_a;
    assign en_b       = ctrl.en_b;
    assign ld_shift_b = ctrl.ld_shift_b;
    assign en_p       = ctrl.en_p;
    assign ld_add_p   = ctrl.ld_add_p;
    assign busy       = ctrl.busy;
    assign done       = ctrl.done;
    assign iter_cnt   = cnt_val;

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter N_BITS, default 4: multiplier width and maximum number of shift-add iterations.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level request to begin a multiply.
REQ-005 zero  input  1  datapath flag: multiplier register equals 0.
REQ-006 lsb_b  input  1  datapath flag: multiplier register bit 0.
REQ-007 en_a, ld_shift_a  output  1 each  multiplicand register enable and shift/load select (1 = shift).
REQ-008 en_b, ld_shift_b  output  1 each  multiplier register enable and shift/load select (1 = shift).
REQ-009 en_p, ld_add_p  output  1 each  product register enable and accumulate/clear select (1 = add).
REQ-010 busy  output  1  operation in progress, high in every state except IDLE and DONE.
REQ-011 done  output  1  result valid on the datapath product output.
REQ-012 iter_cnt  output  $clog2(N_BITS+1)  number of completed shift iterations.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, TEST, ADD, SHIFT and DONE; all outputs are Moore (state-decoded, registered state).
REQ-014 IDLE: all enables and selects low; start=1 moves to LOAD on the next edge.
REQ-015 LOAD (1 cycle): en_a=en_b=en_p=1, all selects 0 (load a, load b, clear p); iter_cnt <= 0; next state TEST.
REQ-016 TEST: enables low; if iter_cnt==N_BITS go to DONE; else if lsb_b=1 go to ADD; else go to SHIFT.
REQ-017 ADD (1 cycle): en_p=1, ld_add_p=1; next state SHIFT.
REQ-018 SHIFT (1 cycle): en_a=en_b=1, ld_shift_a=ld_shift_b=1; iter_cnt increments; next state TEST.
REQ-019 DONE: done=1, enables low; stays in DONE while start=1; returns to IDLE on the first edge that samples start=0.
REQ-020 Latency, start-sampling edge to done rising: 2 + 2*N_BITS + (number of 1 bits in b) edges (10 to 14 for N_BITS=4).
REQ-021 start while busy or in DONE SHALL be ignored; no restart without passing through IDLE.
REQ-022 iter_cnt SHALL never exceed N_BITS and SHALL hold its value in DONE and IDLE until the next LOAD.
REQ-023 ADD and SHIFT SHALL never be asserted in the same cycle; no two register enables with conflicting selects.

Reset
REQ-024 clr_n low SHALL immediately force state IDLE, iter_cnt=0 and every output 0, including mid-operation; datapath contents are don't-care after an aborted operation.
REQ-025 After clr_n deasserts, start is first honoured on the first rising edge at which it is sampled high.

Configuration
REQ-026 Macro MULT_CTRL_EARLY_EXIT_EN defined: TEST also goes to DONE when zero=1, checked before lsb_b; latency becomes 2 + 2*(index of highest set bit of b, plus 1) + popcount(b), and 2 edges for b=0.
REQ-027 Macro undefined: zero is ignored; the fixed N_BITS-iteration schedule of REQ-020 applies.

Structure
REQ-028 Shared package mult_pkg SHALL hold the state enumeration (binary encoding, IDLE=0) and the default N_BITS constant.
REQ-029 The iteration counter SHALL be a sub-module mult_iter_counter with clear, increment and terminal-count output.

Verification
REQ-030 a=3, b=5, macro off: done rises 12 edges after start, product=15, iter_cnt=4.
REQ-031 a=15, b=15, macro off: done at edge 14, product=225; four ADD states observed.
REQ-032 b=0, macro on: done at edge 2, product=0; macro off: done at edge 10, product=0.
REQ-033 start held high through DONE: done stays high, no second LOAD; start drops -> IDLE next edge, busy=0.
REQ-034 clr_n pulsed low during SHIFT of a=7, b=6: all outputs 0 asynchronously; a new start then gives product=42.
